// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
// Types and constants shared by the mips_cpu_bus memory-port arbiter and
// its requester policy.
//   arb_state_t : arbiter FSM states
//   req_id_t    : requester identity (REQ_IFETCH = m0, REQ_DATA = m1)
//   BE_WORD     : all four byte lanes enabled
//   LAT_W       : width of the read-latency counter (READ_LATENCY 1..7)
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1,
        RDWAIT
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t    REQ_IFETCH = 1'b0;
    localparam req_id_t    REQ_DATA   = 1'b1;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam int         LAT_W      = 3;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// mips_bus_arbiter_if
// One Avalon-style memory-port link. The same bundle is used between each
// requester and the arbiter and between the arbiter and memory.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives waitrequest/readdatavalid/readdata
//   slave modport  : the opposite direction
// The memory side carries no readdatavalid of its own (the read latency is
// fixed), so the arbiter ignores that member on its master link.
interface mips_bus_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              waitrequest;
    logic              readdatavalid;
    logic [31:0]       readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/mips_bus_arb_policy.sv
// mips_bus_arb_policy
// Combinational winner select between instruction fetch (req0) and
// load/store (req1).
//   req0, req1  : request present (read | write) from m0 / m1
//   last_grant  : requester granted most recently
//   req_any     : at least one request present
//   winner      : selected requester (only meaningful when req_any)
// Build option MIPS_BUS_ARB_RR_EN: when defined, a tie goes to the requester
// that did not win last time; otherwise m1 (data) always beats m0 (fetch).
module mips_bus_arb_policy
    import mips_bus_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last_grant,
    output logic    req_any,
    output req_id_t winner
);

    assign req_any = req0 | req1;

`ifdef MIPS_BUS_ARB_RR_EN
    always_comb begin
        if (req0 && req1) begin
            winner = (last_grant == REQ_DATA) ? REQ_IFETCH : REQ_DATA;
        end else if (req1) begin
            winner = REQ_DATA;
        end else begin
            winner = REQ_IFETCH;
        end
    end
`else
    assign winner = req1 ? REQ_DATA : REQ_IFETCH;

    // Fixed priority never looks at history; the arbiter still tracks it.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
// Shares the single memory port of mips_cpu_bus between instruction fetch
// (m0) and load/store (m1), one transfer in flight at a time.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   m0, m1       : requester links (slave modport)
//   mem          : memory link (master modport)
//   readdata_out : memory readdata, also broadcast on m0/m1 readdata
//   err          : sticky protocol error (dropped request, read+write)
// Build option MIPS_BUS_ARB_RR_EN selects round-robin arbitration
// (see mips_bus_arb_policy); default is fixed priority m1 > m0.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_bus_arbiter_if.slave  m0,
    mips_bus_arbiter_if.slave  m1,
    mips_bus_arbiter_if.master mem,
    output logic [31:0]        readdata_out,
    output logic               err
);

    arb_state_t       state_q, state_d;
    req_id_t          last_grant_q, last_grant_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             err_q, err_d;

    logic    req0, req1, req_any;
    req_id_t winner;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    mips_bus_arb_policy u_policy (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .req_any    (req_any),
        .winner     (winner)
    );

    // last_grant always names the current owner while in OWNx or RDWAIT.
    logic              owning, sel_data, sel_read, sel_write, rd_done;
    logic [ADDR_W-1:0] sel_address;
    logic [31:0]       sel_writedata;
    logic [3:0]        sel_byteenable;

    assign owning         = (state_q == OWN0) || (state_q == OWN1);
    assign sel_data       = (last_grant_q == REQ_DATA);
    assign sel_address    = sel_data ? m1.address    : m0.address;
    assign sel_read       = sel_data ? m1.read       : m0.read;
    assign sel_write      = sel_data ? m1.write      : m0.write;
    assign sel_writedata  = sel_data ? m1.writedata  : m0.writedata;
    assign sel_byteenable = sel_data ? m1.byteenable : m0.byteenable;

    // Write wins when a requester raises both strobes; the read is dropped.
    assign mem.address    = owning ? sel_address    : '0;
    assign mem.read       = owning & sel_read & ~sel_write;
    assign mem.write      = owning & sel_write;
    assign mem.writedata  = owning ? sel_writedata  : '0;
    assign mem.byteenable = owning ? sel_byteenable : '0;

    assign m0.waitrequest = (state_q == OWN0) ? mem.waitrequest : 1'b1;
    assign m1.waitrequest = (state_q == OWN1) ? mem.waitrequest : 1'b1;

    assign rd_done          = (state_q == RDWAIT) && (lat_cnt_q == LAT_W'(1));
    assign m0.readdatavalid = rd_done & ~sel_data;
    assign m1.readdatavalid = rd_done &  sel_data;

    assign m0.readdata   = mem.readdata;
    assign m1.readdata   = mem.readdata;
    assign readdata_out  = mem.readdata;
    assign err           = err_q;

    logic unused_mem_rdv;
    assign unused_mem_rdv = mem.readdatavalid;

    always_comb begin
        // NOTE: every *_d gets a default up front so no path infers a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_cnt_d    = lat_cnt_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d      = (winner == REQ_DATA) ? OWN1 : OWN0;
                    last_grant_d = winner;
                end
            end
            OWN0, OWN1: begin
                if (!(sel_read || sel_write)) begin
                    // Owner gave up before memory accepted the command.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    if (sel_read && sel_write) err_d = 1'b1;
                    if (!mem.waitrequest) begin
                        if (sel_write) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = RDWAIT;
                            lat_cnt_d = LAT_W'(READ_LATENCY);
                        end
                    end
                end
            end
            RDWAIT: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                if (lat_cnt_q <= LAT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_DATA;
            lat_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_cnt_q    <= lat_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter
// Scoreboard bench for mips_bus_arbiter: the initial block plays both CPU
// requesters, an always block plays a byte-addressed memory, and a negedge
// monitor pops expected commands/read returns as the DUT produces them.
// Honors MIPS_BUS_ARB_RR_EN for the arbitration-order expectations.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    localparam int RL = 3;
    localparam int TO = 100;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } cmd_t;

    typedef struct packed {
        req_id_t     who;
        logic [31:0] data;
    } rd_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] readdata_out;
    logic        err;

    int n_checks   = 0;
    int n_bad      = 0;
    int cyc        = 0;
    int accept_cyc = 0;
    int rdv_seen   = 0;

    cmd_t exp_cmd_q[$];
    rd_t  exp_rd_q[$];

    logic [7:0] mem [0:255];
    logic [7:0] rd_addr;

    mips_bus_arbiter_if #(.ADDR_W(32)) m0_bus ();
    mips_bus_arbiter_if #(.ADDR_W(32)) m1_bus ();
    mips_bus_arbiter_if #(.ADDR_W(32)) mem_bus ();

    mips_bus_arbiter #(
        .READ_LATENCY (RL),
        .ADDR_W       (32)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .mem          (mem_bus),
        .readdata_out (readdata_out),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    function automatic logic [7:0] init_byte(input int a);
        case (a)
            16:      return 8'hEF;
            17:      return 8'hBE;
            18:      return 8'hAD;
            19:      return 8'hDE;
            default: return 8'hAA;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            rd_addr <= 8'h00;
        end else begin
            if (mem_bus.write && !mem_bus.waitrequest) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_bus.byteenable[b])
                        mem[8'(mem_bus.address[7:0] + 8'(b))] <= mem_bus.writedata[8*b +: 8];
                end
            end
            if (mem_bus.read && !mem_bus.waitrequest) rd_addr <= mem_bus.address[7:0];
        end
    end

    assign mem_bus.readdata = {mem[8'(rd_addr + 8'd3)], mem[8'(rd_addr + 8'd2)],
                               mem[8'(rd_addr + 8'd1)], mem[rd_addr]};
    assign mem_bus.readdatavalid = 1'b0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] be);
        cmd_t c;
        c = '{rd: rd, wr: wr, addr: addr, data: data, be: be};
        exp_cmd_q.push_back(c);
    endtask

    task automatic expect_rd(input req_id_t who, input logic [31:0] data);
        rd_t r;
        r = '{who: who, data: data};
        exp_rd_q.push_back(r);
    endtask

    task automatic mon_accept();
        cmd_t e;
        check("cmd_pending", 64'(exp_cmd_q.size() != 0), 64'(1));
        if (exp_cmd_q.size() != 0) begin
            e = exp_cmd_q.pop_front();
            check("cmd_kind", {mem_bus.read, mem_bus.write, mem_bus.byteenable}, {e.rd, e.wr, e.be});
            check("cmd_addr", mem_bus.address, e.addr);
            check("cmd_wdata", mem_bus.writedata, e.data);
        end
        if (mem_bus.read) accept_cyc = cyc;
    endtask

    task automatic mon_rdv();
        rd_t e;
        rdv_seen++;
        check("rdv_pending", 64'(exp_rd_q.size() != 0), 64'(1));
        check("rdv_onehot", m0_bus.readdatavalid & m1_bus.readdatavalid, 0);
        if (exp_rd_q.size() != 0) begin
            e = exp_rd_q.pop_front();
            check("rdv_who", m1_bus.readdatavalid, e.who);
            check("rdv_data", readdata_out, e.data);
            check("rdv_bus_data", (e.who == REQ_DATA) ? m1_bus.readdata : m0_bus.readdata, e.data);
            check("rdv_latency", 64'(cyc - accept_cyc), 64'(RL));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if ((mem_bus.read || mem_bus.write) && !mem_bus.waitrequest) mon_accept();
            if (m0_bus.readdatavalid || m1_bus.readdatavalid) mon_rdv();
        end
    end

    // ---------------- requester side ----------------
    task automatic set_cmd(input req_id_t who, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (who == REQ_DATA) begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = addr;
            m1_bus.writedata = data; m1_bus.byteenable = be;
        end else begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = addr;
            m0_bus.writedata = data; m0_bus.byteenable = be;
        end
    endtask

    function automatic logic wait_of(input req_id_t who);
        return (who == REQ_DATA) ? m1_bus.waitrequest : m0_bus.waitrequest;
    endfunction

    // Hold a command until the arbiter accepts it, then release it.
    task automatic issue(input req_id_t who, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        int n = 0;
        set_cmd(who, rd, wr, addr, data, be);
        do begin
            @(negedge clk);
            n++;
        end while (wait_of(who) && n < TO);
        check("accept_timeout", 64'(n < TO), 64'(1));
        @(posedge clk);
        #1;
        set_cmd(who, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rd_q.size() != 0 || exp_cmd_q.size() != 0) && n < TO) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < TO), 64'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic t4_watch();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_bus.write && n < TO);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            check("t4_hold_write", mem_bus.write, 1);
            check("t4_hold_addr", mem_bus.address, 32'h50);
            check("t4_hold_data", mem_bus.writedata, 32'h11223344);
            check("t4_m0_wait", m0_bus.waitrequest, 1);
            check("t4_m1_wait", m1_bus.waitrequest, 1);
        end
        @(posedge clk);
        #1 mem_bus.waitrequest = 1'b0;
        @(negedge clk);
        check("t4_m0_wait_accept", m0_bus.waitrequest, 1);
        check("t4_m1_wait_accept", m1_bus.waitrequest, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int rdv_before;
        set_cmd(REQ_IFETCH, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(REQ_DATA, 1'b0, 1'b0, '0, '0, '0);
        mem_bus.waitrequest = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", {mem_bus.read, mem_bus.write, m0_bus.waitrequest,
                                   m1_bus.waitrequest, err}, 5'b00110);
        end
        check("idle_address", mem_bus.address, 0);

        // 2: single fetch read
        expect_cmd(1'b1, 1'b0, 32'h10, 32'h0, BE_WORD);
        expect_rd(REQ_IFETCH, 32'hDEADBEEF);
        issue(REQ_IFETCH, 1'b1, 1'b0, 32'h10, 32'h0, BE_WORD);
        @(negedge clk);
        check("t2_read_one_cycle", mem_bus.read, 0);
        drain();

        // 3: simultaneous fetch read and data write, last_grant = m1 after reset
        apply_reset();
`ifdef MIPS_BUS_ARB_RR_EN
        expect_cmd(1'b1, 1'b0, 32'h20, 32'h0, BE_WORD);
        expect_cmd(1'b0, 1'b1, 32'h20, 32'h12345678, 4'b0011);
        expect_rd(REQ_IFETCH, 32'hAAAAAAAA);
`else
        expect_cmd(1'b0, 1'b1, 32'h20, 32'h12345678, 4'b0011);
        expect_cmd(1'b1, 1'b0, 32'h20, 32'h0, BE_WORD);
        expect_rd(REQ_IFETCH, 32'hAAAA5678);
`endif
        fork
            issue(REQ_IFETCH, 1'b1, 1'b0, 32'h20, 32'h0, BE_WORD);
            issue(REQ_DATA, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'b0011);
        join
        drain();
        check("t3_mem_bytes", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'hAAAA5678);

        // 4: write stalled by memory for 3 cycles
        mem_bus.waitrequest = 1'b1;
        expect_cmd(1'b0, 1'b1, 32'h50, 32'h11223344, BE_WORD);
        fork
            issue(REQ_DATA, 1'b0, 1'b1, 32'h50, 32'h11223344, BE_WORD);
            t4_watch();
        join
        drain();
        check("t4_mem_word", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h11223344);

        // 5: reset while waiting on read data
        rdv_before = rdv_seen;
        expect_cmd(1'b1, 1'b0, 32'h10, 32'h0, BE_WORD);
        issue(REQ_IFETCH, 1'b1, 1'b0, 32'h10, 32'h0, BE_WORD);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_reset_strobes", {mem_bus.read, mem_bus.write, m0_bus.readdatavalid,
                                   m1_bus.readdatavalid, err}, 5'b00000);
        check("t5_reset_wait", {m0_bus.waitrequest, m1_bus.waitrequest}, 2'b11);
        check("t5_reset_bus", {mem_bus.address, mem_bus.byteenable}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_stale_rdv", 64'(rdv_seen), 64'(rdv_before));
        check("t5_idle_wait", {m0_bus.waitrequest, m1_bus.waitrequest}, 2'b11);

        // 6a: read and write together from m0
        check("t6_err_clean", err, 0);
        expect_cmd(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, BE_WORD);
        issue(REQ_IFETCH, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, BE_WORD);
        @(negedge clk);
        check("t6_both_err", err, 1);
        check("t6_both_idle", {mem_bus.read, mem_bus.write, m0_bus.waitrequest,
                               m1_bus.waitrequest}, 4'b0011);
        drain();
        check("t6_both_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hCAFEF00D);
        expect_cmd(1'b0, 1'b1, 32'h44, 32'h0BADF00D, BE_WORD);
        issue(REQ_DATA, 1'b0, 1'b1, 32'h44, 32'h0BADF00D, BE_WORD);
        drain();
        check("t6_err_sticky", err, 1);
        apply_reset();
        @(negedge clk);
        check("t6_err_reset", err, 0);

        // 6b: m1 drops its read while memory stalls
        mem_bus.waitrequest = 1'b1;
        set_cmd(REQ_DATA, 1'b1, 1'b0, 32'h60, 32'h0, BE_WORD);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_bus.read && n < TO);
        check("t6_drop_owned", mem_bus.read, 1);
        @(posedge clk);
        #1 set_cmd(REQ_DATA, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check("t6_drop_idle", {mem_bus.read, mem_bus.write, m0_bus.waitrequest,
                               m1_bus.waitrequest}, 4'b0011);
        check("t6_drop_err", err, 1);
        mem_bus.waitrequest = 1'b0;
        expect_cmd(1'b1, 1'b0, 32'h10, 32'h0, BE_WORD);
        expect_rd(REQ_IFETCH, 32'hDEADBEEF);
        issue(REQ_IFETCH, 1'b1, 1'b0, 32'h10, 32'h0, BE_WORD);
        drain();
        check("t6_drop_err_sticky", err, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
